// File: rtl/spi_target_if.sv
// spi_target_if: SPI pins plus TX/RX byte handshakes of spi_target.
// slave = the target block, master = host/consumer side.
interface spi_target_if;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_overrun_clr;
  logic       cs_active;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi,
    input  tx_data, tx_valid,
    input  rx_ready, rx_overrun_clr,
    output spi_miso, spi_miso_oe,
    output tx_ready, tx_underrun,
    output rx_data, rx_valid, rx_overrun,
    output cs_active
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi,
    output tx_data, tx_valid,
    output rx_ready, rx_overrun_clr,
    input  spi_miso, spi_miso_oe,
    input  tx_ready, tx_underrun,
    input  rx_data, rx_valid, rx_overrun,
    input  cs_active
  );
endinterface

// File: rtl/spi_target.sv
// spi_target: oversampled SPI mode-0 target, MSB first, 8-bit frames.
// Define SPI_TARGET_RXFIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO.
module spi_target #(
  parameter logic [7:0] TX_IDLE       = 8'hFF,
  parameter int         RX_FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  spi_target_if.slave bus
);

  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  logic       cs_act_q;
  logic [2:0] bitcnt_q;
  logic [6:0] shift_rx_q;
  logic [7:0] shift_tx_q;
  logic       oe_q;
  logic       und_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       ovr_q;

  logic       cs_on;
  logic       cs_fall;
  logic       cs_rise;
  logic       in_frame;
  logic       sck_rise;
  logic       sck_fall;
  logic       load;
  logic [7:0] load_val;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       rx_pop;
  logic       rx_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q    <= 3'b000;
      cs_q     <= 2'b11;
      mosi_q   <= 2'b00;
      cs_act_q <= 1'b0;
    end else begin
      sck_q    <= {sck_q[1:0], bus.spi_sck};
      cs_q     <= {cs_q[0], bus.spi_cs_n};
      mosi_q   <= {mosi_q[0], bus.spi_mosi};
      cs_act_q <= ~cs_q[1];
    end
  end

  assign cs_on     = ~cs_q[1];
  assign cs_fall   = cs_on & ~cs_act_q;
  assign cs_rise   = ~cs_on & cs_act_q;
  assign in_frame  = cs_on & cs_act_q;
  assign sck_rise  = in_frame & sck_q[1] & ~sck_q[2];
  assign sck_fall  = in_frame & ~sck_q[1] & sck_q[2];

  // Frame start and every byte boundary fetch the next TX byte
  assign load      = cs_fall | (sck_fall & (bitcnt_q == 3'd0));
  assign load_val  = hold_full_q ? hold_q : TX_IDLE;
  assign byte_done = sck_rise & (bitcnt_q == 3'd7);
  assign rx_byte   = {shift_rx_q, mosi_q[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q   <= 3'd0;
      shift_rx_q <= 7'd0;
      shift_tx_q <= 8'd0;
      oe_q       <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      und_q <= load & ~hold_full_q;
      if (load) begin
        shift_tx_q <= load_val;
      end else if (sck_fall) begin
        shift_tx_q <= {shift_tx_q[6:0], 1'b0};
      end
      if (cs_rise) begin
        bitcnt_q <= 3'd0;
        oe_q     <= 1'b0;
      end else if (cs_fall) begin
        bitcnt_q   <= 3'd0;
        oe_q       <= 1'b1;
        shift_rx_q <= 7'd0;
      end else if (sck_rise) begin
        shift_rx_q <= {shift_rx_q[5:0], mosi_q[1]};
        bitcnt_q   <= bitcnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
    end else if (load && hold_full_q) begin
      hold_full_q <= 1'b0;
    end else if (bus.tx_valid && !hold_full_q) begin
      hold_q      <= bus.tx_data;
      hold_full_q <= 1'b1;
    end
  end

`ifdef SPI_TARGET_RXFIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [7:0] mem_q [RX_FIFO_DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        full;
  logic        empty;
  logic        push;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rx_pop  = ~empty & bus.rx_ready;
  // A pop in the same clk frees the slot the push lands in
  assign push    = byte_done & (~full | rx_pop);
  assign rx_drop = byte_done & full & ~rx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= rx_byte;
        wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (rx_pop) begin
        rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign bus.rx_data  = mem_q[rptr_q[AW-1:0]];
  assign bus.rx_valid = ~empty;
`else
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       unused_cfg;

  assign unused_cfg = ^RX_FIFO_DEPTH;
  assign rx_pop     = rx_valid_q & bus.rx_ready;
  assign rx_drop    = byte_done & rx_valid_q & ~rx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else if (byte_done && (!rx_valid_q || rx_pop)) begin
      rx_data_q  <= rx_byte;
      rx_valid_q <= 1'b1;
    end else if (rx_pop) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (bus.rx_overrun_clr) begin
      ovr_q <= 1'b0;
    end else if (rx_drop) begin
      ovr_q <= 1'b1;
    end
  end

  assign bus.spi_miso    = oe_q & shift_tx_q[7];
  assign bus.spi_miso_oe = oe_q;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.tx_underrun = und_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.cs_active   = cs_act_q;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized host/consumer bench with a byte-level
// reference model and an RX scoreboard drained by a monitor.
module tb_spi_target;

  localparam int HALF = 3;
  localparam logic [7:0] IDLE = 8'hFF;
`ifdef SPI_TARGET_RXFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_target_if bus ();

  spi_target dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  logic       mh_full = 1'b0;
  logic [7:0] mh_data = 8'h00;
  int         exp_und = 0;
  int         obs_und = 0;
  logic       exp_ovr = 1'b0;
  logic       hold_rx = 1'b0;

  function automatic void check(string nm, logic [31:0] got,
                                logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  // Next byte the target will shift out, from the holding model
  function automatic logic [7:0] model_load();
    if (mh_full) begin
      mh_full = 1'b0;
      return mh_data;
    end
    exp_und++;
    return IDLE;
  endfunction

  function automatic void model_rx(logic [7:0] b);
    if (hold_rx && rxq.size() >= CAP) exp_ovr = 1'b1;
    else rxq.push_back(b);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus.tx_underrun) obs_und++;
        if (bus.rx_valid && bus.rx_ready) begin
          if (rxq.size() == 0) begin
            check("rx_extra", {24'd0, bus.rx_data}, 32'hDEAD);
          end else begin
            check("rx_data", {24'd0, bus.rx_data},
                  {24'd0, rxq.pop_front()});
          end
        end
      end
    end
  end

  task automatic check_reset(string tag);
    check({tag, "_miso"}, bus.spi_miso, 0);
    check({tag, "_oe"}, bus.spi_miso_oe, 0);
    check({tag, "_txrdy"}, bus.tx_ready, 1);
    check({tag, "_und"}, bus.tx_underrun, 0);
    check({tag, "_rxd"}, bus.rx_data, 0);
    check({tag, "_rxv"}, bus.rx_valid, 0);
    check({tag, "_ovr"}, bus.rx_overrun, 0);
    check({tag, "_csa"}, bus.cs_active, 0);
  endtask

  task automatic tx_push(input logic [7:0] b);
    int n = 0;
    while (!bus.tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) begin
      check("tx_push_timeout", 0, 1);
      return;
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    mh_full = 1'b1;
    mh_data = b;
    check("tx_ready_low", bus.tx_ready, 0);
  endtask

  task automatic host_byte(input logic [7:0] mo, input int nb,
                           input int pv, output logic [7:0] mi);
    logic [7:0] pb;
    pb = pv[7:0];
    mi = 8'h00;
    for (int j = 0; j < nb; j++) begin
      bus.spi_mosi = mo[7-j];
      repeat (HALF) @(negedge clk);
      mi[7-j] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      if (j == 3 && pv >= 0) begin
        tx_push(pb);
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.spi_sck = 1'b0;
    end
  endtask

  // One CS window; the last byte carries lb bits (lb < 8 = aborted)
  task automatic session(input logic [7:0] mq[$], input int pq[$],
                         input int lb);
    logic [7:0] cur;
    logic [7:0] mi;
    int nb;
    int pv;
    bus.spi_cs_n = 1'b0;
    cur = model_load();
    repeat (6) @(negedge clk);
    check("cs_active", bus.cs_active, 1);
    check("miso_oe_on", bus.spi_miso_oe, 1);
    for (int k = 0; k < mq.size(); k++) begin
      nb = (k == mq.size() - 1) ? lb : 8;
      pv = (pq[k] >= 0 && !mh_full) ? pq[k] : -1;
      host_byte(mq[k], nb, pv, mi);
      if (nb == 8) begin
        check("miso_byte", {24'd0, mi}, {24'd0, cur});
        model_rx(mq[k]);
        cur = model_load();
      end
    end
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("miso_oe_off", bus.spi_miso_oe, 0);
    check("miso_idle", bus.spi_miso, 0);
    check("underrun_cnt", obs_und, exp_und);
    check("rx_overrun", bus.rx_overrun, exp_ovr);
  endtask

  task automatic drain();
    int n = 0;
    while (rxq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_drain", rxq.size(), 0);
  endtask

  initial begin
    logic [7:0] mq[$];
    int         pq[$];
    logic [7:0] r;
    logic [7:0] mi;
    int         nbytes;

    rst = 1'b1;
    bus.spi_sck        = 1'b0;
    bus.spi_cs_n       = 1'b1;
    bus.spi_mosi       = 1'b0;
    bus.tx_data        = 8'h00;
    bus.tx_valid       = 1'b0;
    bus.rx_ready       = 1'b1;
    bus.rx_overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame with a TX byte queued
    bus.spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    r = 8'($urandom);
    host_byte(r, 5, 8'h77, mi);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    bus.spi_cs_n = 1'b1;
    bus.spi_sck  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mh_full = 1'b0;
    exp_und = 0;
    obs_und = 0;
    repeat (4) @(negedge clk);
    mq.delete(); pq.delete();
    mq.push_back(8'($urandom)); pq.push_back(-1);
    session(mq, pq, 8);
    drain();

    // Queued 0x3C returned while host sends 0xA5
    tx_push(8'h3C);
    mq.delete(); pq.delete();
    mq.push_back(8'hA5); pq.push_back(-1);
    session(mq, pq, 8);
    check("tx_ready_back", bus.tx_ready, 1);
    drain();

    // Nothing queued: idle byte and underrun pulses
    mq.delete(); pq.delete();
    mq.push_back(8'h00); pq.push_back(-1);
    session(mq, pq, 8);
    drain();

    // Consumer stalls: storage fills, then overrun
    repeat (10) @(negedge clk);
    hold_rx = 1'b1;
    bus.rx_ready = 1'b0;
    mq.delete(); pq.delete();
    for (int k = 0; k <= CAP; k++) begin
      mq.push_back(8'((k + 1) * 17));
      pq.push_back(-1);
    end
    session(mq, pq, 8);
    check("hold_rxv", bus.rx_valid, 1);
    check("hold_head", {24'd0, bus.rx_data}, {24'd0, rxq[0]});
    bus.rx_overrun_clr = 1'b1;
    @(negedge clk);
    bus.rx_overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_clr", bus.rx_overrun, 0);
    hold_rx = 1'b0;
    bus.rx_ready = 1'b1;
    drain();

    // Aborted 4-bit frame keeps the queued byte, then 0x5A
    mq.delete(); pq.delete();
    mq.push_back(8'($urandom)); pq.push_back(8'hE7);
    session(mq, pq, 4);
    check("abort_rxv", bus.rx_valid, 0);
    mq.delete(); pq.delete();
    mq.push_back(8'h5A); pq.push_back(-1);
    session(mq, pq, 8);
    drain();

    // Back-to-back frames, TX fed just in time
    tx_push(8'h01);
    mq.delete(); pq.delete();
    for (int k = 0; k < 3; k++) mq.push_back(8'($urandom));
    pq.push_back(2); pq.push_back(3);
    pq.push_back(int'($urandom_range(0, 255)));
    session(mq, pq, 8);
    drain();

    for (int s = 0; s < 6; s++) begin
      if (!mh_full && $urandom_range(0, 1) == 1) tx_push(8'($urandom));
      nbytes = int'($urandom_range(1, 3));
      mq.delete(); pq.delete();
      for (int k = 0; k < nbytes; k++) begin
        mq.push_back(8'($urandom));
        if ($urandom_range(0, 1) == 1) pq.push_back(int'($urandom_range(0, 255)));
        else pq.push_back(-1);
      end
      session(mq, pq, 8);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
